triage_dispatcher: RTL
======================

// Module: triage_dispatcher
// PURPOSE
//   Dequeue-side consumer of the patient priority queue. When a doctor room is
//   free and the queue is non-empty, it issues a one-cycle dequeue request and
//   captures the returned 4-bit patient word {priority[1:0], id[1:0]}.
//   It then holds the patient for a priority-scaled consultation time and
//   signals discharge. It sits between the queue and the room/display logic.
// PARAMETERS
//   BASE_CYCLES  4  consultation cycles per priority step; service = BASE_CYCLES*(pri+1)
//   TIMER_W      8  service timer width; BASE_CYCLES*4 must be <= 2**TIMER_W-1
//   CNT_W        8  width of served-patient counters
// PORTS
//   clk           in   1      system clock; all logic on posedge
//   rst           in   1      synchronous, active-high reset
//   q_empty       in   1      queue holds no patients
//   q_data        in   4      queue output word; valid the cycle after q_deq
//   q_deq         out  1      dequeue request to queue, one-cycle pulse
//   doctor_ready  in   1      doctor present in room; 0 pauses service
//   busy          out  1      patient currently in room (WAIT/SERVE/DONE)
//   cur_id        out  2      ID of patient being served
//   cur_pri       out  2      priority of patient being served
//   done          out  1      one-cycle discharge pulse
//   served_cnt    out  CNT_W  total patients discharged, saturating
//   pri_cnt       out  4*CNT_W  per-priority discharge counts (TRIAGE_STATS_EN only)
// BEHAVIOUR
//   Reset: state=IDLE; q_deq=0, busy=0, cur_id=0, cur_pri=0, done=0,
//     served_cnt=0, pri_cnt=0, timer=0. Reset mid-service drops the patient; no dequeue is reissued.
//   FSM, all outputs registered:
//   - IDLE: if !q_empty && doctor_ready -> REQ, else stay.
//   - REQ: q_deq=1 for exactly this cycle -> WAIT.
//   - WAIT: q_deq=0, busy=1; at end of cycle latch cur_pri=q_data[3:2],
//     cur_id=q_data[1:0], timer=BASE_CYCLES*(q_data[3:2]+1)-1 -> SERVE.
//   - SERVE: busy=1. Timer decrements only while doctor_ready=1; at timer==0
//     with doctor_ready=1 -> DONE.
//   - DONE: done=1 for one cycle, busy=1, served_cnt+1 (saturates at
//     2**CNT_W-1) -> IDLE. cur_id/cur_pri hold until next WAIT capture.
//   Latency: q_deq asserts 1 cycle after IDLE sees the condition. done asserts
//     BASE_CYCLES*(pri+1) ready cycles after the WAIT cycle.
//   Minimum per-patient period: 3 + BASE_CYCLES*(pri+1) cycles.
//   Boundaries:
//   - q_empty sampled only in IDLE; never issue q_deq while q_empty=1.
//   - doctor_ready low in IDLE blocks requests.
//   - doctor_ready low in WAIT does not block capture.
//   - doctor_ready low in SERVE freezes the timer; busy stays 1.
//   - q_empty rising during WAIT/SERVE is ignored.
//   - done and a new q_deq never occur in the same cycle.
// CONFIGURATION
//   TRIAGE_STATS_EN defined:
//     pri_cnt[k*CNT_W +: CNT_W] increments in DONE when cur_pri==k.
//     Each count saturates independently. Cleared by rst.
//   TRIAGE_STATS_EN undefined:
//     pri_cnt port and counters are absent. All other behaviour is identical.
// TESTING
//   1 rst=1 for 2 cycles -> all outputs 0; q_empty=1, doctor_ready=1 for
//     20 cycles -> q_deq stays 0.
//   2 q_empty=0, q_data=4'b1110 after q_deq -> cur_pri=3, cur_id=2;
//     done exactly 16 cycles after the WAIT cycle; served_cnt=1.
//   3 q_data=4'b0001, doctor_ready dropped for 5 cycles mid-SERVE ->
//     done at 4+5 cycles after WAIT; busy stays 1 throughout.
//   4 queue non-empty, doctor_ready=0 -> no q_deq. Raise doctor_ready ->
//     q_deq pulses once, width 1 cycle.
//   5 rst asserted during SERVE -> next cycle busy=0, done=0, served_cnt=0;
//     no done pulse follows.
//   6 TRIAGE_STATS_EN: serve pri 0,3,3,1 -> pri_cnt = {2,0,1,1} (pri3..pri0);
//     300 discharges -> served_cnt=255.

Source files
------------

// File: rtl/triage_dispatcher.sv
// ============================================================================
// Module  : triage_dispatcher
// Brief   : Dequeues patients when a doctor is free and times a priority-scaled
//           consultation. Optional per-priority stats: define TRIAGE_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module triage_dispatcher #(
  parameter int BASE_CYCLES = 4,
  parameter int TIMER_W     = 8,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               q_empty_i,
  input  logic [3:0]         q_data_i,
  output logic               q_deq_o,
  input  logic               doctor_ready_i,
  output logic               busy_o,
  output logic [1:0]         cur_id_o,
  output logic [1:0]         cur_pri_o,
  output logic               done_o,
`ifdef TRIAGE_STATS_EN
  output logic [4*CNT_W-1:0] pri_cnt_o,
`endif
  output logic [CNT_W-1:0]   served_cnt_o
);

  localparam int unsigned c_ST_W = 3;
  localparam logic [c_ST_W-1:0] c_IDLE  = 3'd0;
  localparam logic [c_ST_W-1:0] c_REQ   = 3'd1;
  localparam logic [c_ST_W-1:0] c_WAIT  = 3'd2;
  localparam logic [c_ST_W-1:0] c_SERVE = 3'd3;
  localparam logic [c_ST_W-1:0] c_DONE  = 3'd4;

  logic [c_ST_W-1:0]  state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         cur_id_q, cur_id_d;
  logic [1:0]         cur_pri_q, cur_pri_d;
  logic [CNT_W-1:0]   served_q, served_d;
  logic               q_deq_q, q_deq_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [TIMER_W-1:0] svc_len;

  // Timer is loaded with N-1 so that DONE lands N ready cycles after WAIT.
  assign svc_len = TIMER_W'(BASE_CYCLES) * (TIMER_W'(q_data_i[3:2]) + TIMER_W'(1))
                 - TIMER_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_IDLE;
      timer_q   <= '0;
      cur_id_q  <= '0;
      cur_pri_q <= '0;
      served_q  <= '0;
      q_deq_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cur_id_q  <= cur_id_d;
      cur_pri_q <= cur_pri_d;
      served_q  <= served_d;
      q_deq_q   <= q_deq_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cur_id_d  = cur_id_q;
    cur_pri_d = cur_pri_q;
    case (state_q)
      c_IDLE: begin
        if (!q_empty_i && doctor_ready_i) state_d = c_REQ;
      end
      c_REQ: state_d = c_WAIT;
      c_WAIT: begin
        cur_pri_d = q_data_i[3:2];
        cur_id_d  = q_data_i[1:0];
        timer_d   = svc_len;
        state_d   = (svc_len == '0) ? c_DONE : c_SERVE;
      end
      c_SERVE: begin
        if (doctor_ready_i) begin
          if (timer_q <= TIMER_W'(1)) begin
            timer_d = '0;
            state_d = c_DONE;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
      end
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    q_deq_d  = (state_d == c_REQ);
    busy_d   = (state_d == c_WAIT) || (state_d == c_SERVE) || (state_d == c_DONE);
    done_d   = (state_d == c_DONE);
    served_d = served_q;
    if (state_q == c_DONE && served_q != '1) served_d = served_q + CNT_W'(1);
  end

`ifdef TRIAGE_STATS_EN
  for (genvar k = 0; k < 4; k++) begin : g_pri_cnt
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (state_q == c_DONE && cur_pri_q == 2'(k) && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
    assign pri_cnt_o[k*CNT_W +: CNT_W] = cnt_q;
  end
`endif

  assign q_deq_o      = q_deq_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign cur_id_o     = cur_id_q;
  assign cur_pri_o    = cur_pri_q;
  assign served_cnt_o = served_q;

endmodule

`default_nettype wire
